csr_file: RTL and testbench
===========================

# csr_file

Parametrised machine-mode CSR file for the core: it replaces the fixed CSR register set with a file that has configurable hardware performance counters, counter inhibit, and read-modify-write operations (write/set/clear) decoded inside the block. It also has a read-only interrupt-pending register and a single-cycle trap entry/`mret` state update. It sits beside `ex` and `clint`. `ex` issues CSR accesses; the trap sequencer drives `trap_i`/`mret_i`.

## Interface
- `NUM_HPM`, 4: number of `mhpmcounter3+k` counters, legal range 0..29.
- `MTVEC_RESET`, 32'h0: reset value of `mtvec`; bits [1:0] are ignored.
- `clk`  in  1  core clock.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `ex_req_i`  in  1  CSR access valid this cycle.
- `ex_op_i`  in  2  operation: 00 read, 01 write, 10 set, 11 clear.
- `ex_addr_i`  in  12  CSR address.
- `ex_wdata_i`  in  32  operand (rs1 or zimm).
- `ex_rdata_o`  out  32  old CSR value; 0 when `ex_req_i`=0 or the access is illegal.
- `ex_illegal_o`  out  1  access is illegal.
- `instret_i`  in  1  one instruction retired this cycle.
- `hpm_event_i`  in  NUM_HPM  event pulses, one per HPM counter.
- `trap_i`  in  1  trap entry.
- `trap_cause_i`  in  32  cause value for `mcause`.
- `trap_pc_i`  in  32  PC to save in `mepc`.
- `mret_i`  in  1  return from trap.
- `irq_timer_i`, `irq_ext_i`  in  1 each  level interrupt sources, appearing as `mip`.MTIP and `mip`.MEIP.
- `mtvec_o`, `mepc_o`  out  32  current register values.
- `global_int_en_o`  out  1  value of `mstatus`.MIE.
- `int_pending_o`  out  1  `mstatus`.MIE & |(`mip` & `mie`).

## Operation
- **Implemented registers:**
  - `mstatus` 0x300: MIE bit 3 and MPIE bit 7 are writable; MPP [12:11] reads 2'b11; all other bits read 0.
  - `mie` 0x304: writable bits 7 and 11 only.
  - `mip` 0x344: read-only; bit 7 = `irq_timer_i`, bit 11 = `irq_ext_i`.
  - `mtvec` 0x305: bits [1:0] forced 0.
  - `mepc` 0x341: bits [1:0] forced 0.
  - `mcause` 0x342 and `mscratch` 0x340: full 32 bits.
  - `mcountinhibit` 0x320: bit 0 CY, bit 2 IR, bits 3+k HPM; all other bits read 0.
  - Counters: `mcycle`/`mcycleh` 0xB00/0xB80, `minstret`/`minstreth` 0xB02/0xB82, `mhpmcounter(3+k)`/`h` 0xB03+k/0xB83+k.
  - Read-only shadows: `cycle`/`cycleh` 0xC00/0xC80, `instret`/`instreth` 0xC02/0xC82.
- **New value:** write gives wdata; set gives old|wdata; clear gives old&~wdata. Read (00) never writes.
- **Illegal access:** the address is unimplemented, or a write happens to the read-only space (addr[11:10]=2'b11, or `mip`). Here "a write happens" means op 01, or op 10/11 with wdata≠0. An illegal access changes no state.
- **Counters:** all are 64-bit.
  - Increment conditions: `mcycle` every cycle; `minstret` on `instret_i`; HPM k on `hpm_event_i[k]`. Each increments only if its inhibit bit is 0.
  - A software write to one half replaces that half. The counter does not increment that cycle, and the other half holds.
  - Wrap: all-ones wraps to 0.
- **Trap entry** (`trap_i`), at the edge:
  - `mepc` <= `trap_pc_i` & ~3, `mcause` <= `trap_cause_i`.
  - MPIE <= MIE, MIE <= 0.
- **`mret_i`**, at the edge: MIE <= MPIE, MPIE <= 1.
- **Priority:** `trap_i` > `mret_i` > `ex` write. A losing `ex` write is dropped, but its `ex_rdata_o` is still driven. Counter increments continue regardless.
- **Reset values:**
  - All registers 0, except `mtvec` = `MTVEC_RESET`&~3 and `mcountinhibit` = 0 (all counting).
  - Outputs follow: `global_int_en_o`=0, `int_pending_o`=0, `ex_rdata_o`=0, `ex_illegal_o`=0.

## Timing
- `ex_rdata_o`/`ex_illegal_o` are combinational from the request and the registered state, and return the pre-write value. There is no write-data bypass.
- Writes, trap and `mret` take effect at the next rising `clk`; a read in the following cycle sees the new value.
- Counter reads return the registered count, i.e. the value before this cycle's increment.
- `int_pending_o` is combinational from the registered `mstatus`/`mie` and the live irq inputs.
- Asserting `rst` mid-operation clears state immediately (asynchronously); the first update happens at the first edge after deassertion.

## Structure
- Package `csr_pkg`: CSR address constants, `ex_op_i` encodings, `mstatus`/`mip` bit positions, and the `mcountinhibit` bit map.
- Sub-module `csr_counter`: 64-bit counter with `inc`, `inhibit`, `we_lo`, `we_hi`, `wdata` inputs; instantiated 2+NUM_HPM times via generate.

## Test plan
- Reset with `MTVEC_RESET`=32'h8000_0103 -> read 0x305 returns 32'h8000_0100. `ex_illegal_o`=0.
- Set (op 10) on 0x300 with wdata 8 -> `ex_rdata_o` 32'h1800. Next cycle `global_int_en_o`=1; with `mie`=32'h80 and `irq_timer_i`=1, `int_pending_o`=1.
- MIE=1, then `trap_i` with cause 32'h8000_0007 and pc 32'h0000_1236 -> `mepc_o`=32'h1234, `mcause`=32'h8000_0007, MIE=0, MPIE=1. Then `mret_i` -> MIE=1, MPIE=1.
- Write 32'hFFFF_FFFE to 0xB00 -> next read of 0xB00 is 32'hFFFF_FFFE. Two cycles later 0xB80 has incremented by 1. Set `mcountinhibit` bit 0 -> 0xB00 frozen.
- Write op to 0xC00, or read of 0x7C0 -> `ex_illegal_o`=1, `ex_rdata_o`=0, no state change. Clear of 0xC00 with wdata 0 -> legal, returns `cycle`.
- `trap_i` and an `ex` write to 0x341 of 32'hABCD_0000 in the same cycle -> `mepc` takes `trap_pc_i`&~3. A pulse on `hpm_event_i[NUM_HPM-1]` increments the last HPM counter exactly once.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, operation
// encodings, register bit positions and small decode helpers.
package csr_pkg;

    localparam logic [11:0] ADDR_MSTATUS       = 12'h300;
    localparam logic [11:0] ADDR_MIE           = 12'h304;
    localparam logic [11:0] ADDR_MTVEC         = 12'h305;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;
    localparam logic [11:0] ADDR_MEPC          = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE        = 12'h342;
    localparam logic [11:0] ADDR_MIP           = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } csr_op_e;

    localparam int          MSTATUS_MIE  = 3;
    localparam int          MSTATUS_MPIE = 7;
    localparam logic [31:0] MSTATUS_MPP  = 32'h0000_1800;
    localparam int          MIP_MTIP     = 7;
    localparam int          MIP_MEIP     = 11;
    localparam logic [31:0] MIE_WMASK    = 32'h0000_0880;

    localparam int CNTINH_CY   = 0;
    localparam int CNTINH_IR   = 2;
    localparam int CNTINH_HPM0 = 3;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_MSTATUS,
        SEL_MIE,
        SEL_MIP,
        SEL_MTVEC,
        SEL_MEPC,
        SEL_MCAUSE,
        SEL_MSCRATCH,
        SEL_MCOUNTINHIBIT,
        SEL_COUNTER
    } csr_sel_e;

    // Counter index 0 = cycle, 1 = instret, 2+k = hpm k. The offset is both
    // the low address offset from 0xB00 and the mcountinhibit bit position.
    function automatic logic [11:0] cnt_offset(input int idx);
        return (idx == 0) ? 12'd0 : 12'(idx + 1);
    endfunction

    function automatic logic [31:0] cntinh_mask(input int num_hpm);
        logic [31:0] m;
        m = 32'h0;
        m[CNTINH_CY] = 1'b1;
        m[CNTINH_IR] = 1'b1;
        for (int k = 0; k < num_hpm; k++) m[CNTINH_HPM0 + k] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] csr_rmw(input csr_op_e op, input logic [31:0] old_val,
                                            input logic [31:0] wdata);
        case (op)
            OP_WRITE: return wdata;
            OP_SET:   return old_val | wdata;
            OP_CLEAR: return old_val & ~wdata;
            default:  return old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter.sv
// 64-bit performance counter with per-half software writes and an inhibit.
// A software write to either half suppresses that cycle's increment.
module csr_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    input  logic        i_inhibit,
    input  logic        i_we_lo,
    input  logic        i_we_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_count
);

    logic [63:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_we_lo) begin
            r_count[31:0] <= i_wdata;
        end else if (i_we_hi) begin
            r_count[63:32] <= i_wdata;
        end else if (i_inc && !i_inhibit) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: decoded read/write/set/clear access, performance
// counters with inhibit, read-only mip, and trap entry / mret updates.
module csr_file
    import csr_pkg::*;
#(
    parameter int          NUM_HPM     = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   ex_req_i,
    input  logic [1:0]                             ex_op_i,
    input  logic [11:0]                            ex_addr_i,
    input  logic [31:0]                            ex_wdata_i,
    output logic [31:0]                            ex_rdata_o,
    output logic                                   ex_illegal_o,
    input  logic                                   instret_i,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event_i,
    input  logic                                   trap_i,
    input  logic [31:0]                            trap_cause_i,
    input  logic [31:0]                            trap_pc_i,
    input  logic                                   mret_i,
    input  logic                                   irq_timer_i,
    input  logic                                   irq_ext_i,
    output logic [31:0]                            mtvec_o,
    output logic [31:0]                            mepc_o,
    output logic                                   global_int_en_o,
    output logic                                   int_pending_o
);

    localparam int          NCNT       = 2 + NUM_HPM;
    localparam logic [31:0] CNTINH_MSK = cntinh_mask(NUM_HPM);

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mscratch;
    logic [31:0] r_mcountinhibit;

    csr_sel_e    w_sel;
    logic        w_ro;
    logic [4:0]  w_cnt_idx;
    logic        w_cnt_hi;
    logic [63:0] w_cnt_val;
    logic [31:0] w_old;
    logic [31:0] w_new;
    logic [31:0] w_mip;
    logic [31:0] w_mstatus;
    logic        w_wr_attempt;
    logic        w_illegal;
    logic        w_we;
    csr_op_e     w_op;

    logic [63:0]     w_count [NCNT];
    logic [NCNT-1:0] w_inc;

    assign w_op      = csr_op_e'(ex_op_i);
    assign w_mip     = (32'(irq_timer_i) << MIP_MTIP) | (32'(irq_ext_i) << MIP_MEIP);
    assign w_mstatus = MSTATUS_MPP | (32'(r_mstatus_mpie) << MSTATUS_MPIE)
                                   | (32'(r_mstatus_mie)  << MSTATUS_MIE);

    // NOTE: every signal driven here gets a default first so no path through
    // the case/loop leaves it unassigned, which would infer a latch.
    always_comb begin
        w_sel     = SEL_NONE;
        w_ro      = (ex_addr_i[11:10] == 2'b11);
        w_cnt_idx = '0;
        w_cnt_hi  = 1'b0;
        case (ex_addr_i)
            ADDR_MSTATUS:       w_sel = SEL_MSTATUS;
            ADDR_MIE:           w_sel = SEL_MIE;
            ADDR_MTVEC:         w_sel = SEL_MTVEC;
            ADDR_MCOUNTINHIBIT: w_sel = SEL_MCOUNTINHIBIT;
            ADDR_MSCRATCH:      w_sel = SEL_MSCRATCH;
            ADDR_MEPC:          w_sel = SEL_MEPC;
            ADDR_MCAUSE:        w_sel = SEL_MCAUSE;
            ADDR_MIP: begin
                w_sel = SEL_MIP;
                w_ro  = 1'b1;
            end
            default: begin
                for (int i = 0; i < NCNT; i++) begin
                    if (ex_addr_i == ADDR_MCYCLE + cnt_offset(i) ||
                        (i < 2 && ex_addr_i == ADDR_CYCLE + cnt_offset(i))) begin
                        w_sel     = SEL_COUNTER;
                        w_cnt_idx = 5'(i);
                        w_cnt_hi  = 1'b0;
                    end
                    if (ex_addr_i == ADDR_MCYCLEH + cnt_offset(i) ||
                        (i < 2 && ex_addr_i == ADDR_CYCLEH + cnt_offset(i))) begin
                        w_sel     = SEL_COUNTER;
                        w_cnt_idx = 5'(i);
                        w_cnt_hi  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_cnt_val = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (w_cnt_idx == 5'(i)) w_cnt_val = w_count[i];
        end
    end

    always_comb begin
        w_old = '0;
        case (w_sel)
            SEL_MSTATUS:       w_old = w_mstatus;
            SEL_MIE:           w_old = r_mie;
            SEL_MIP:           w_old = w_mip;
            SEL_MTVEC:         w_old = r_mtvec;
            SEL_MEPC:          w_old = r_mepc;
            SEL_MCAUSE:        w_old = r_mcause;
            SEL_MSCRATCH:      w_old = r_mscratch;
            SEL_MCOUNTINHIBIT: w_old = r_mcountinhibit;
            SEL_COUNTER:       w_old = w_cnt_hi ? w_cnt_val[63:32] : w_cnt_val[31:0];
            default:           w_old = '0;
        endcase
    end

    // Set/clear with a zero operand is a pure read and may target read-only space.
    assign w_wr_attempt = (w_op == OP_WRITE) ||
                          ((w_op == OP_SET || w_op == OP_CLEAR) && (ex_wdata_i != 32'h0));
    assign w_illegal    = ex_req_i && ((w_sel == SEL_NONE) || (w_wr_attempt && w_ro));
    assign w_we         = ex_req_i && !w_illegal && w_wr_attempt && !trap_i && !mret_i;
    assign w_new        = csr_rmw(w_op, w_old, ex_wdata_i);

    assign ex_rdata_o   = (ex_req_i && !w_illegal) ? w_old : 32'h0;
    assign ex_illegal_o = w_illegal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mstatus_mie   <= 1'b0;
            r_mstatus_mpie  <= 1'b0;
            r_mie           <= '0;
            r_mtvec         <= MTVEC_RESET & ~32'h3;
            r_mepc          <= '0;
            r_mcause        <= '0;
            r_mscratch      <= '0;
            r_mcountinhibit <= '0;
        end else begin
            if (trap_i) begin
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
                r_mepc         <= trap_pc_i & ~32'h3;
                r_mcause       <= trap_cause_i;
            end else if (mret_i) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (w_we) begin
                case (w_sel)
                    SEL_MSTATUS: begin
                        r_mstatus_mie  <= w_new[MSTATUS_MIE];
                        r_mstatus_mpie <= w_new[MSTATUS_MPIE];
                    end
                    SEL_MIE:           r_mie           <= w_new & MIE_WMASK;
                    SEL_MTVEC:         r_mtvec         <= w_new & ~32'h3;
                    SEL_MEPC:          r_mepc          <= w_new & ~32'h3;
                    SEL_MCAUSE:        r_mcause        <= w_new;
                    SEL_MSCRATCH:      r_mscratch      <= w_new;
                    SEL_MCOUNTINHIBIT: r_mcountinhibit <= w_new & CNTINH_MSK;
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        localparam int OFF = (g == 0) ? 0 : g + 1;
        logic w_sel_this;

        if (g == 0) begin : g_cy
            assign w_inc[g] = 1'b1;
        end else if (g == 1) begin : g_ir
            assign w_inc[g] = instret_i;
        end else begin : g_hpm
            assign w_inc[g] = hpm_event_i[g-2];
        end

        assign w_sel_this = w_we && (w_sel == SEL_COUNTER) && (w_cnt_idx == 5'(g));

        csr_counter u_counter (
            .clk       (clk),
            .rst       (rst),
            .i_inc     (w_inc[g]),
            .i_inhibit (r_mcountinhibit[OFF]),
            .i_we_lo   (w_sel_this && !w_cnt_hi),
            .i_we_hi   (w_sel_this && w_cnt_hi),
            .i_wdata   (w_new),
            .o_count   (w_count[g])
        );
    end

    assign mtvec_o         = r_mtvec;
    assign mepc_o          = r_mepc;
    assign global_int_en_o = r_mstatus_mie;
    assign int_pending_o   = r_mstatus_mie && |(w_mip & r_mie);

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: CSR responses go through a scoreboard
// queue; register outputs are compared directly against bench constants.
module tb_csr_file;

    localparam int NUM_HPM = 4;

    logic               clk;
    logic               rst;
    logic               ex_req_i;
    logic [1:0]         ex_op_i;
    logic [11:0]        ex_addr_i;
    logic [31:0]        ex_wdata_i;
    logic [31:0]        ex_rdata_o;
    logic               ex_illegal_o;
    logic               instret_i;
    logic [NUM_HPM-1:0] hpm_event_i;
    logic               trap_i;
    logic [31:0]        trap_cause_i;
    logic [31:0]        trap_pc_i;
    logic               mret_i;
    logic               irq_timer_i;
    logic               irq_ext_i;
    logic [31:0]        mtvec_o;
    logic [31:0]        mepc_o;
    logic               global_int_en_o;
    logic               int_pending_o;

    csr_file #(
        .NUM_HPM     (NUM_HPM),
        .MTVEC_RESET (32'h8000_0103)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_req_i        (ex_req_i),
        .ex_op_i         (ex_op_i),
        .ex_addr_i       (ex_addr_i),
        .ex_wdata_i      (ex_wdata_i),
        .ex_rdata_o      (ex_rdata_o),
        .ex_illegal_o    (ex_illegal_o),
        .instret_i       (instret_i),
        .hpm_event_i     (hpm_event_i),
        .trap_i          (trap_i),
        .trap_cause_i    (trap_cause_i),
        .trap_pc_i       (trap_pc_i),
        .mret_i          (mret_i),
        .irq_timer_i     (irq_timer_i),
        .irq_ext_i       (irq_ext_i),
        .mtvec_o         (mtvec_o),
        .mepc_o          (mepc_o),
        .global_int_en_o (global_int_en_o),
        .int_pending_o   (int_pending_o)
    );

    localparam logic [1:0] RD = 2'b00, WR = 2'b01, ST = 2'b10, CL = 2'b11;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        illegal;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned model_cycle;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles elapsed since reset release; only valid until mcycle is first written.
    always @(posedge clk or negedge rst) begin
        if (!rst) model_cycle <= 0;
        else      model_cycle <= model_cycle + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // One access per clock; inputs change 1 time unit after the rising edge.
    task automatic csr_access(input string tag, input logic [1:0] op, input logic [11:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_ill);
        exp_t e;
        e.tag = tag; e.rdata = exp_rdata; e.illegal = exp_ill;
        sb_q.push_back(e);
        ex_req_i = 1'b1; ex_op_i = op; ex_addr_i = addr; ex_wdata_i = wdata;
        @(negedge clk);
        check({tag, " sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, " rdata"}, ex_rdata_o, e.rdata);
            check({e.tag, " illegal"}, ex_illegal_o, e.illegal);
        end
        @(posedge clk);
        #1;
        ex_req_i = 1'b0; ex_op_i = RD; ex_addr_i = '0; ex_wdata_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        ex_req_i = 1'b0; ex_op_i = RD; ex_addr_i = '0; ex_wdata_i = '0;
        instret_i = 1'b0; hpm_event_i = '0;
        trap_i = 1'b0; trap_cause_i = '0; trap_pc_i = '0; mret_i = 1'b0;
        irq_timer_i = 1'b1; irq_ext_i = 1'b0;

        repeat (2) @(negedge clk);
        check("rst mtvec_o", mtvec_o, 32'h8000_0100);
        check("rst mepc_o", mepc_o, 32'h0);
        check("rst gie", global_int_en_o, 1'b0);
        check("rst int_pending", int_pending_o, 1'b0);
        check("rst rdata", ex_rdata_o, 32'h0);
        check("rst illegal", ex_illegal_o, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        csr_access("rd mtvec", RD, 12'h305, 32'h0, 32'h8000_0100, 1'b0);
        csr_access("set mstatus", ST, 12'h300, 32'h8, 32'h0000_1800, 1'b0);
        check("gie after set", global_int_en_o, 1'b1);
        csr_access("wr mie", WR, 12'h304, 32'h0000_0080, 32'h0, 1'b0);
        check("int_pending timer", int_pending_o, 1'b1);
        csr_access("rd mip", RD, 12'h344, 32'h0, 32'h0000_0080, 1'b0);
        csr_access("rd mstatus mie", RD, 12'h300, 32'h0, 32'h0000_1808, 1'b0);

        trap_i = 1'b1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h0000_1236;
        csr_access("wr mepc vs trap", WR, 12'h341, 32'hABCD_0000, 32'h0, 1'b0);
        trap_i = 1'b0;
        check("trap mepc_o", mepc_o, 32'h0000_1234);
        check("trap gie", global_int_en_o, 1'b0);
        check("trap int_pending", int_pending_o, 1'b0);
        csr_access("rd mcause", RD, 12'h342, 32'h0, 32'h8000_0007, 1'b0);
        csr_access("rd mstatus trap", RD, 12'h300, 32'h0, 32'h0000_1880, 1'b0);

        mret_i = 1'b1;
        csr_access("wr mscratch vs mret", WR, 12'h340, 32'h55, 32'h0, 1'b0);
        mret_i = 1'b0;
        check("mret gie", global_int_en_o, 1'b1);
        csr_access("rd mstatus mret", RD, 12'h300, 32'h0, 32'h0000_1888, 1'b0);
        csr_access("rd mscratch dropped", RD, 12'h340, 32'h0, 32'h0, 1'b0);
        csr_access("wr mscratch", WR, 12'h340, 32'hCAFE_F00D, 32'h0, 1'b0);
        csr_access("clr mscratch", CL, 12'h340, 32'hF000_000F, 32'hCAFE_F00D, 1'b0);
        csr_access("set mscratch", ST, 12'h340, 32'h1, 32'h0AFE_F000, 1'b0);
        csr_access("rd mscratch", RD, 12'h340, 32'h0, 32'h0AFE_F001, 1'b0);
        csr_access("wr mtvec", WR, 12'h305, 32'h0000_1237, 32'h8000_0100, 1'b0);
        check("mtvec_o aligned", mtvec_o, 32'h0000_1234);

        csr_access("wr mcycle", WR, 12'hB00, 32'hFFFF_FFFE, model_cycle, 1'b0);
        csr_access("wr mcycleh", WR, 12'hB80, 32'h1234_5678, 32'h0, 1'b0);
        csr_access("rd mcycle", RD, 12'hB00, 32'h0, 32'hFFFF_FFFE, 1'b0);
        csr_access("rd mcycleh pre", RD, 12'hB80, 32'h0, 32'h1234_5678, 1'b0);
        csr_access("rd mcycleh wrap", RD, 12'hB80, 32'h0, 32'h1234_5679, 1'b0);
        csr_access("clr0 cycle", CL, 12'hC00, 32'h0, 32'h1, 1'b0);
        csr_access("wr inhibit cy", WR, 12'h320, 32'h1, 32'h0, 1'b0);
        csr_access("rd mcycle frozen", RD, 12'hB00, 32'h0, 32'h3, 1'b0);
        csr_access("wr cycle ro", WR, 12'hC00, 32'hDEAD, 32'h0, 1'b1);
        csr_access("rd mcycle still", RD, 12'hB00, 32'h0, 32'h3, 1'b0);
        csr_access("rd cycleh", RD, 12'hC80, 32'h0, 32'h1234_5679, 1'b0);
        csr_access("rd inhibit", RD, 12'h320, 32'h0, 32'h1, 1'b0);
        csr_access("rd unimpl", RD, 12'h7C0, 32'h0, 32'h0, 1'b1);
        csr_access("set mip ro", ST, 12'h344, 32'h80, 32'h0, 1'b1);
        csr_access("set0 mip", ST, 12'h344, 32'h0, 32'h80, 1'b0);
        csr_access("rd hpmcounter3 shadow", RD, 12'hC03, 32'h0, 32'h0, 1'b1);

        instret_i = 1'b1;
        csr_access("rd minstret", RD, 12'hB02, 32'h0, 32'h0, 1'b0);
        instret_i = 1'b0;
        csr_access("rd instret", RD, 12'hC02, 32'h0, 32'h1, 1'b0);
        csr_access("rd instreth", RD, 12'hC82, 32'h0, 32'h0, 1'b0);

        hpm_event_i[NUM_HPM-1] = 1'b1;
        csr_access("rd hpm6 pre", RD, 12'hB06, 32'h0, 32'h0, 1'b0);
        hpm_event_i = '0;
        csr_access("rd hpm6 once", RD, 12'hB06, 32'h0, 32'h1, 1'b0);
        csr_access("rd hpm6 hold", RD, 12'hB06, 32'h0, 32'h1, 1'b0);
        csr_access("rd hpm3", RD, 12'hB03, 32'h0, 32'h0, 1'b0);
        hpm_event_i[NUM_HPM-1] = 1'b1;
        csr_access("wr hpm6", WR, 12'hB06, 32'h10, 32'h1, 1'b0);
        hpm_event_i = '0;
        csr_access("rd hpm6 written", RD, 12'hB06, 32'h0, 32'h10, 1'b0);

        ex_req_i = 1'b0; ex_addr_i = 12'h300; ex_op_i = RD;
        @(negedge clk);
        check("idle rdata", ex_rdata_o, 32'h0);
        check("idle illegal", ex_illegal_o, 1'b0);

        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async rst mtvec_o", mtvec_o, 32'h8000_0100);
        check("async rst mepc_o", mepc_o, 32'h0);
        check("async rst gie", global_int_en_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        csr_access("rd mscratch post rst", RD, 12'h340, 32'h0, 32'h0, 1'b0);
        csr_access("rd inhibit post rst", RD, 12'h320, 32'h0, 32'h0, 1'b0);
        csr_access("rd hpm6 post rst", RD, 12'hB06, 32'h0, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
